// File: rtl/conversion_deserializer_if.sv
// conversion_deserializer_if: serial-bit input and word handshake bundle for conversion_deserializer.
// Optional word_parity present when CONVERSION_DESER_PARITY_EN is defined.
interface conversion_deserializer_if #(parameter int WIDTH = 8);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             in_frame;
  logic             overflow;
`ifdef CONVERSION_DESER_PARITY_EN
  logic             word_parity;
  modport master (output bit_in, bit_valid, frame_start, word_ready,
                  input  word_out, word_valid, in_frame, overflow, word_parity);
  modport slave  (input  bit_in, bit_valid, frame_start, word_ready,
                  output word_out, word_valid, in_frame, overflow, word_parity);
`else
  modport master (output bit_in, bit_valid, frame_start, word_ready,
                  input  word_out, word_valid, in_frame, overflow);
  modport slave  (input  bit_in, bit_valid, frame_start, word_ready,
                  output word_out, word_valid, in_frame, overflow);
`endif
endinterface

// File: rtl/conversion_deserializer.sv
// conversion_deserializer: LSB-first serial-to-parallel word assembler with a one-deep output register.
// Define CONVERSION_DESER_PARITY_EN to add the registered word_parity output.
module conversion_deserializer #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  conversion_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] full_word;
  logic             valid;
  logic             in_frame_q;
  logic             ovf;
  logic             collect_bit;
  logic             done;
  logic             load;
`ifdef CONVERSION_DESER_PARITY_EN
  logic             parity;
  assign bus.word_parity = parity;
`endif
  // frame_start always wins over a plain data bit: it restarts the word
  assign collect_bit = (state == COLLECT) && bus.bit_valid && !bus.frame_start;
  assign done        = collect_bit && (cnt == CW'(WIDTH - 1));
  assign load        = done && (!valid || bus.word_ready);
  assign full_word   = shift | (WIDTH'(bus.bit_in) << (WIDTH - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      word       <= '0;
      valid      <= 1'b0;
      in_frame_q <= 1'b0;
      ovf        <= 1'b0;
`ifdef CONVERSION_DESER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (bus.frame_start) begin
        state      <= COLLECT;
        in_frame_q <= 1'b1;
        cnt        <= bus.bit_valid ? CW'(1) : '0;
        shift      <= WIDTH'(bus.bit_valid & bus.bit_in);
      end else if (collect_bit) begin
        cnt   <= done ? '0 : cnt + CW'(1);
        shift <= done ? '0 : shift | (WIDTH'(bus.bit_in) << cnt);
      end
      // a completed word either loads (register free or draining now) or is dropped
      if (load) begin
        word  <= full_word;
        valid <= 1'b1;
`ifdef CONVERSION_DESER_PARITY_EN
        parity <= ^full_word;
`endif
      end else if (done) begin
        ovf <= 1'b1;
      end else if (valid && bus.word_ready) begin
        valid <= 1'b0;
      end
    end
  end
  assign bus.word_out   = word;
  assign bus.word_valid = valid;
  assign bus.in_frame   = in_frame_q;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_conversion_deserializer.sv
// tb_conversion_deserializer: directed stimulus with an expected-word queue checked by a negedge monitor.
module tb_conversion_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  conversion_deserializer_if #(.WIDTH(8)) bus();
  conversion_deserializer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // each negedge with valid&&ready is one word the next edge consumes
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h expected none", bus.word_out);
      end else begin
        chk("scoreboard_word", {24'h0, bus.word_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic send_word(input logic [7:0] w, input bit fs);
    for (int i = 0; i < 8; i++) begin
      bus.bit_in = w[i];
      bus.bit_valid = 1'b1;
      bus.frame_start = fs && (i == 0);
      step();
    end
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask
  task automatic drain;
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    chk("drain_valid", {31'h0, bus.word_valid}, 32'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] w;
    do_reset();
    chk("rst_word_out", {24'h0, bus.word_out}, 32'h0);
    chk("rst_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("rst_in_frame", {31'h0, bus.in_frame}, 32'h0);
    chk("rst_overflow", {31'h0, bus.overflow}, 32'h0);
    // basic word 8D, valid exactly one cycle after the 8th bit
    w = 8'h8D;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      bus.bit_in = w[i];
      bus.bit_valid = 1'b1;
      bus.frame_start = (i == 0);
      step();
      if (i == 6) chk("a_valid_early", {31'h0, bus.word_valid}, 32'h0);
    end
    bus.bit_valid = 1'b0;
    chk("a_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("a_word", {24'h0, bus.word_out}, 32'h8D);
    chk("a_overflow", {31'h0, bus.overflow}, 32'h0);
`ifdef CONVERSION_DESER_PARITY_EN
    chk("a_parity", {31'h0, bus.word_parity}, 32'h0);
`endif
    drain();
    chk("a_word_hold", {24'h0, bus.word_out}, 32'h8D);
    // bits before frame_start are ignored in IDLE
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.bit_in = 1'b1;
      bus.bit_valid = 1'b1;
      step();
      chk("b_idle_in_frame", {31'h0, bus.in_frame}, 32'h0);
    end
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1'b1);
    chk("b_in_frame", {31'h0, bus.in_frame}, 32'h1);
    chk("b_word", {24'h0, bus.word_out}, 32'h3C);
    drain();
    // ready held high across a continuous 16-bit stream
    do_reset();
    bus.word_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    send_word(8'hA5, 1'b1);
    chk("c_valid1", {31'h0, bus.word_valid}, 32'h1);
    chk("c_word1", {24'h0, bus.word_out}, 32'hA5);
    send_word(8'h5A, 1'b0);
    chk("c_valid2", {31'h0, bus.word_valid}, 32'h1);
    chk("c_word2", {24'h0, bus.word_out}, 32'h5A);
    chk("c_overflow", {31'h0, bus.overflow}, 32'h0);
    step();
    chk("c_drained", {31'h0, bus.word_valid}, 32'h0);
    // consume and load on the same edge
    bus.word_ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    send_word(8'hA5, 1'b0);
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      bus.bit_in = w[i];
      bus.bit_valid = 1'b1;
      bus.word_ready = (i == 7);
      step();
    end
    bus.bit_valid = 1'b0;
    chk("c_same_edge_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("c_same_edge_word", {24'h0, bus.word_out}, 32'h5A);
    chk("c_same_edge_ovf", {31'h0, bus.overflow}, 32'h0);
    step();
    bus.word_ready = 1'b0;
    chk("c_same_edge_drain", {31'h0, bus.word_valid}, 32'h0);
    // overflow: second word dropped while first is held
    do_reset();
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b1);
    chk("d_ovf_first", {31'h0, bus.overflow}, 32'h0);
    send_word(8'h22, 1'b0);
    chk("d_overflow", {31'h0, bus.overflow}, 32'h1);
    chk("d_word_kept", {24'h0, bus.word_out}, 32'h11);
    chk("d_valid_kept", {31'h0, bus.word_valid}, 32'h1);
    drain();
    chk("d_overflow_sticky", {31'h0, bus.overflow}, 32'h1);
    step();
    chk("d_ready_no_effect", {31'h0, bus.word_valid}, 32'h0);
    // partial word discarded by frame_start
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.bit_in = 1'b1;
      bus.bit_valid = 1'b1;
      bus.frame_start = (i == 0);
      step();
    end
    exp_q.push_back(8'hF0);
    send_word(8'hF0, 1'b1);
    chk("e_word", {24'h0, bus.word_out}, 32'hF0);
    send_word(8'h99, 1'b0);
    chk("e_overflow", {31'h0, bus.overflow}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.bit_in = 1'b1;
      bus.bit_valid = 1'b1;
      bus.frame_start = (i == 0);
      step();
    end
    bus.frame_start = 1'b0;
    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("e_async_word", {24'h0, bus.word_out}, 32'h0);
    chk("e_async_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("e_async_in_frame", {31'h0, bus.in_frame}, 32'h0);
    chk("e_async_overflow", {31'h0, bus.overflow}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("e_idle_after_rst", {31'h0, bus.in_frame}, 32'h0);
    chk("e_no_word_after_rst", {31'h0, bus.word_valid}, 32'h0);
    bus.bit_valid = 1'b0;
    // frame_start without a bit restarts with cnt 0
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 1'b0);
    chk("f_word", {24'h0, bus.word_out}, 32'hC3);
    drain();
`ifdef CONVERSION_DESER_PARITY_EN
    exp_q.push_back(8'h07);
    send_word(8'h07, 1'b0);
    chk("p_parity", {31'h0, bus.word_parity}, 32'h1);
    drain();
`endif
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
